mem_sort_ctrl: RTL and testbench

Hardware sequencer that bubble-sorts a contiguous array of 64-bit words in `Data_Memory` in place. It owns the memory's read/write/address/data ports while busy, and replaces the software-driven compare/swap loop used during memory bring-up. The pipeline-side memory mux selects this block's bus whenever `busy` is high. Sort order is ascending and unsigned.

---
 rtl/mem_sort_ctrl_pkg.sv | 18 +
 rtl/mem_sort_ctrl_if.sv | 20 ++
 rtl/mem_sort_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_sort_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_sort_ctrl_pkg.sv
// Shared types and default constants for the in-place bubble-sort memory sequencer.
package mem_sort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_CMP,
        ST_WR_A,
        ST_WR_B,
        ST_DONE
    } sort_state_t;

    localparam int unsigned SORT_N_ELEM = 10;
    localparam int unsigned SORT_STRIDE = 8;
    localparam logic [63:0] SORT_BASE   = '0;

endpackage

// File: rtl/mem_sort_ctrl_if.sv
// Data_Memory port bundle; the sorter drives it as master while busy.
interface mem_sort_ctrl_if;

    logic        Mem_Read;
    logic        Mem_Write;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic [63:0] Read_Data;

    modport master (
        output Mem_Read, Mem_Write, Mem_Addr, Write_Data,
        input  Read_Data
    );

    modport slave (
        input  Mem_Read, Mem_Write, Mem_Addr, Write_Data,
        output Read_Data
    );

endinterface

// File: rtl/mem_sort_ctrl.sv
// Ascending unsigned in-place bubble sort of N_ELEM 64-bit words in Data_Memory,
// with early exit on a pass that performs no swap.
module mem_sort_ctrl
    import mem_sort_pkg::*;
#(
    parameter int unsigned N_ELEM    = SORT_N_ELEM,
    parameter logic [63:0] BASE_ADDR = SORT_BASE,
    parameter logic [63:0] STRIDE    = 64'(SORT_STRIDE),
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] swap_count,
    mem_sort_ctrl_if.master  mem
);

    localparam int unsigned IDX_W = (N_ELEM < 2) ? 1 : $clog2(N_ELEM);

    sort_state_t      r_state;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [63:0]      r_a;
    logic [63:0]      r_b;
    logic             r_pass_swapped;
    logic [CNT_W-1:0] r_swap_count;

    logic [IDX_W:0]   w_j1;
    logic [IDX_W:0]   w_idx;
    logic [63:0]      w_addr;
    logic             w_last_cmp;
    logic             w_no_swap;
    logic             w_final_pass;

    assign w_j1  = {1'b0, r_j} + (IDX_W + 1)'(1);
    // One shared address adder: second operand of a pair sits at j+1.
    assign w_idx  = (r_state == ST_RD_B || r_state == ST_WR_B) ? w_j1 : {1'b0, r_j};
    assign w_addr = BASE_ADDR + 64'(w_idx) * STRIDE;

    assign w_last_cmp   = 32'(w_j1) >= (N_ELEM - 32'd1 - 32'(r_i));
    assign w_no_swap    = !r_pass_swapped && (r_state == ST_CMP);
    assign w_final_pass = 32'(r_i) == (N_ELEM - 32'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_i            <= '0;
            r_j            <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_pass_swapped <= 1'b0;
            r_swap_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_i            <= '0;
                        r_j            <= '0;
                        r_pass_swapped <= 1'b0;
                        r_swap_count   <= '0;
                        r_state        <= (N_ELEM < 2) ? ST_DONE : ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    r_a     <= mem.Read_Data;
                    r_state <= ST_RD_B;
                end
                ST_RD_B: begin
                    r_b     <= mem.Read_Data;
                    r_state <= ST_CMP;
                end
                ST_WR_A: r_state <= ST_WR_B;
                ST_CMP, ST_WR_B: begin
                    if (r_state == ST_CMP && r_a > r_b) begin
                        r_state <= ST_WR_A;
                    end else begin
                        if (r_state == ST_WR_B) begin
                            r_pass_swapped <= 1'b1;
                            if (r_swap_count != '1)
                                r_swap_count <= r_swap_count + CNT_W'(1);
                        end
                        // Later NBA to r_pass_swapped wins when a new pass opens.
                        if (!w_last_cmp) begin
                            r_j     <= w_j1[IDX_W-1:0];
                            r_state <= ST_RD_A;
                        end else if (w_no_swap || w_final_pass) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_i            <= r_i + IDX_W'(1);
                            r_j            <= '0;
                            r_pass_swapped <= 1'b0;
                            r_state        <= ST_RD_A;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bus is forced idle while reset is high so an interrupted swap never commits its second write.
    always_comb begin
        mem.Mem_Read   = 1'b0;
        mem.Mem_Write  = 1'b0;
        mem.Mem_Addr   = '0;
        mem.Write_Data = '0;
        if (!reset) begin
            case (r_state)
                ST_RD_A, ST_RD_B: begin
                    mem.Mem_Read = 1'b1;
                    mem.Mem_Addr = w_addr;
                end
                ST_WR_A: begin
                    mem.Mem_Write  = 1'b1;
                    mem.Mem_Addr   = w_addr;
                    mem.Write_Data = r_b;
                end
                ST_WR_B: begin
                    mem.Mem_Write  = 1'b1;
                    mem.Mem_Addr   = w_addr;
                    mem.Write_Data = r_a;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign swap_count = r_swap_count;

endmodule

// File: tb/tb_mem_sort_ctrl.sv
// Directed, table-driven bench for mem_sort_ctrl with 10-, 2- and 1-element instances.
module tb_mem_sort_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start10 = 1'b0, start2 = 1'b0, start1 = 1'b0;
    logic busy10, done10, busy2, done2, busy1, done1;
    logic [15:0] sc10, sc2, sc1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_sort_ctrl_if bus10 ();
    mem_sort_ctrl_if bus2 ();
    mem_sort_ctrl_if bus1 ();

    mem_sort_ctrl #(.N_ELEM(10), .BASE_ADDR(64'd0), .STRIDE(64'd8), .CNT_W(16)) dut10 (
        .clk(clk), .reset(reset), .start(start10), .busy(busy10), .done(done10),
        .swap_count(sc10), .mem(bus10)
    );
    mem_sort_ctrl #(.N_ELEM(2), .BASE_ADDR(64'd0), .STRIDE(64'd8), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .swap_count(sc2), .mem(bus2)
    );
    mem_sort_ctrl #(.N_ELEM(1), .BASE_ADDR(64'd0), .STRIDE(64'd8), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .swap_count(sc1), .mem(bus1)
    );

    // Memory models: combinational read, write on rising edge.
    logic [63:0] mem10 [10];
    logic [63:0] ld_vals [10];
    logic        ld10 = 1'b0;
    int          eq_writes = 0;
    int          rw_clash = 0;

    assign bus10.Read_Data = (bus10.Mem_Addr < 64'd80) ? mem10[bus10.Mem_Addr[6:3]] : 64'hDEAD;

    always @(posedge clk) begin
        if (ld10) begin
            for (int k = 0; k < 10; k++) mem10[k] <= ld_vals[k];
        end else if (bus10.Mem_Write && bus10.Mem_Addr < 64'd80) begin
            if (mem10[bus10.Mem_Addr[6:3]] == bus10.Write_Data) eq_writes <= eq_writes + 1;
            mem10[bus10.Mem_Addr[6:3]] <= bus10.Write_Data;
        end
        if ((bus10.Mem_Write && bus10.Mem_Read) || (bus2.Mem_Write && bus2.Mem_Read))
            rw_clash <= rw_clash + 1;
    end

    logic [63:0] mem2 [2];
    logic        ld2 = 1'b0;
    assign bus2.Read_Data = (bus2.Mem_Addr < 64'd16) ? mem2[bus2.Mem_Addr[3]] : 64'hDEAD;

    always @(posedge clk) begin
        if (ld2) begin
            mem2[0] <= 64'd7;
            mem2[1] <= 64'd4;
        end else if (bus2.Mem_Write && bus2.Mem_Addr < 64'd16) begin
            mem2[bus2.Mem_Addr[3]] <= bus2.Write_Data;
        end
    end

    int acc1 = 0;
    assign bus1.Read_Data = 64'd0;
    always @(posedge clk) if (bus1.Mem_Read || bus1.Mem_Write) acc1 <= acc1 + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] init [10];
        logic [63:0] exp  [10];
        int          swaps;
        int          done_cyc;
        int          restart_at;
    } vec_t;

    vec_t vecs [4];

    task automatic load10(input int v);
        for (int k = 0; k < 10; k++) ld_vals[k] = vecs[v].init[k];
        @(negedge clk); ld10 = 1'b1;
        @(negedge clk); ld10 = 1'b0;
    endtask

    task automatic run10(input int v);
        int cyc;
        int eq0;
        load10(v);
        eq0 = eq_writes;
        @(negedge clk); start10 = 1'b1;
        @(negedge clk); start10 = 1'b0; cyc = 1;
        chk({vecs[v].name, "_busy_c1"}, 64'(busy10), 64'd1);
        while (!done10 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start10 = (cyc == vecs[v].restart_at);
        end
        start10 = 1'b0;
        chk({vecs[v].name, "_done_cycle"}, 64'(cyc), 64'(vecs[v].done_cyc));
        chk({vecs[v].name, "_busy_at_done"}, 64'(busy10), 64'd1);
        chk({vecs[v].name, "_swap_count"}, 64'(sc10), 64'(vecs[v].swaps));
        @(negedge clk);
        chk({vecs[v].name, "_idle_after"}, {62'd0, busy10, done10}, 64'd0);
        for (int k = 0; k < 10; k++)
            chk($sformatf("%s_mem%0d", vecs[v].name, k), mem10[k], vecs[v].exp[k]);
        chk({vecs[v].name, "_equal_writes"}, 64'(eq_writes - eq0), 64'd0);
    endtask

    initial begin
        vecs[0].name = "sorted";
        vecs[0].init = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        vecs[0].exp  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        vecs[0].swaps = 0;  vecs[0].done_cyc = 28;  vecs[0].restart_at = 0;
        vecs[1].name = "reversed";
        vecs[1].init = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
        vecs[1].exp  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        vecs[1].swaps = 45; vecs[1].done_cyc = 226; vecs[1].restart_at = 0;
        vecs[2].name = "dups";
        vecs[2].init = '{5, 3, 5, 1, 3, 0, 9, 9, 2, 7};
        vecs[2].exp  = '{0, 1, 2, 3, 3, 5, 5, 7, 9, 9};
        vecs[2].swaps = 19; vecs[2].done_cyc = 165; vecs[2].restart_at = 0;
        vecs[3].name = "restart";
        vecs[3].init = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
        vecs[3].exp  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        vecs[3].swaps = 45; vecs[3].done_cyc = 226; vecs[3].restart_at = 50;

        repeat (2) @(negedge clk);
        chk("rst_busy10", {62'd0, busy10, done10}, 64'd0);
        chk("rst_sc10", 64'(sc10), 64'd0);
        chk("rst_bus10_strobes", {62'd0, bus10.Mem_Read, bus10.Mem_Write}, 64'd0);
        chk("rst_bus10_addr", bus10.Mem_Addr, 64'd0);
        chk("rst_bus10_wdata", bus10.Write_Data, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy2_busy1", {60'd0, busy2, done2, busy1, done1}, 64'd0);

        for (int v = 0; v < 4; v++) run10(v);

        // Reset in the WR_B cycle of the first swap of the reversed array.
        load10(1);
        @(negedge clk); start10 = 1'b1;
        @(negedge clk); start10 = 1'b0;
        repeat (3) @(negedge clk);
        chk("wra_write", {63'd0, bus10.Mem_Write}, 64'd1);
        chk("wra_data", bus10.Write_Data, 64'd9);
        @(negedge clk);
        chk("wrb_addr", bus10.Mem_Addr, 64'd8);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy_done", {62'd0, busy10, done10}, 64'd0);
        chk("midrst_bus", {62'd0, bus10.Mem_Read, bus10.Mem_Write} | bus10.Mem_Addr | bus10.Write_Data, 64'd0);
        chk("midrst_mem0", mem10[0], 64'd9);
        chk("midrst_mem1", mem10[1], 64'd9);
        reset = 1'b0;
        run10(1);

        // Two-element array {7,4}.
        @(negedge clk); ld2 = 1'b1;
        @(negedge clk); ld2 = 1'b0;
        begin
            int cyc;
            @(negedge clk); start2 = 1'b1;
            @(negedge clk); start2 = 1'b0; cyc = 1;
            while (!done2 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            chk("n2_done_cycle", 64'(cyc), 64'd6);
            chk("n2_swap_count", 64'(sc2), 64'd1);
            @(negedge clk);
            chk("n2_mem0", mem2[0], 64'd4);
            chk("n2_mem1", mem2[1], 64'd7);
        end

        // Single element, start held high re-triggers after each DONE.
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); chk("n1_done_c1", 64'(done1), 64'd1);
        @(negedge clk); chk("n1_idle_c2", {62'd0, busy1, done1}, 64'd0);
        @(negedge clk); chk("n1_done_c3", 64'(done1), 64'd1);
        start1 = 1'b0;
        @(negedge clk); chk("n1_idle_c4", {62'd0, busy1, done1}, 64'd0);
        chk("n1_sc", 64'(sc1), 64'd0);
        chk("n1_mem_access", 64'(acc1), 64'd0);
        chk("rw_clash", 64'(rw_clash), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
